// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and default constants for the instruction
//                fetch stage: FSM state encoding, default widths, reset
//                vector, pc step, queue depth and the queue entry layout.
//  Revision    : 1.0 - initial parametrised fetch stage
// ============================================================================
package fetch_pkg;

    localparam int unsigned C_ADDR_W   = 32;
    localparam int unsigned C_INST_W   = 32;
    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
    localparam int unsigned C_PC_STEP  = 4;
    localparam int unsigned C_QDEPTH   = 4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    // Layout of one queue entry at the default widths; the queue itself is
    // built on a flat vector so it follows the module parameters.
    typedef struct packed {
        logic [C_INST_W-1:0] inst;
        logic [C_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Bundle of the fetch stage's I-memory, control and decode
//                handshake signals.
//                master : the fetch unit (drives ice/iaddr, id_*, misalign)
//                slave  : the environment (memory, branch unit, decode)
//  Signals     : ice, iaddr, idata, redirect_valid, redirect_pc, halt,
//                id_valid, id_inst, id_pc, id_ready, misalign
//  Revision    : 1.0 - initial parametrised fetch stage
// ============================================================================
interface fetch_if #(
    parameter int unsigned ADDR_W = fetch_pkg::C_ADDR_W,
    parameter int unsigned INST_W = fetch_pkg::C_INST_W
);
    logic              ice;
    logic [ADDR_W-1:0] iaddr;
    logic [INST_W-1:0] idata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              id_valid;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    logic              id_ready;
    logic              misalign;

    modport master (
        output ice, iaddr, id_valid, id_inst, id_pc, misalign,
        input  idata, redirect_valid, redirect_pc, halt, id_ready
    );

    modport slave (
        input  ice, iaddr, id_valid, id_inst, id_pc, misalign,
        output idata, redirect_valid, redirect_pc, halt, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous FIFO holding fetched {inst, pc} entries toward
//                decode. Flush empties it in one cycle. The caller never
//                pushes when full nor pops when empty.
//  Ports       : clk, rst_n (sync, active-low), push/push_data,
//                pop/pop_data (head, valid when !empty), flush,
//                count, full, empty
//  Revision    : 1.0 - initial parametrised fetch stage
// ============================================================================
module fetch_queue #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned WIDTH  = 64
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    input  wire logic                     flush,
    output logic      [WIDTH-1:0]         pop_data,
    output logic      [$clog2(QDEPTH):0]  count,
    output logic                          full,
    output logic                          empty
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [QDEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + PTR_W'(1);
            if (pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wptr] <= push_data;
    end

    assign pop_data = r_mem[r_rptr];
    assign count    = r_count;
    assign full     = (r_count == CNT_W'(QDEPTH));
    assign empty    = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues sequential I-memory reads
//                against a fixed 1-cycle synchronous memory, buffers the
//                returned words in a queue toward decode, and supports
//                redirect (with flush/squash), halt and decode backpressure.
//  Ports       : clk, rst_n (sync, active-low), bus (fetch_if.master)
//  Options     : FETCH_MISALIGN_CHK_EN - misaligned redirect targets set a
//                sticky misalign flag and lock the stage in S_HALT.
//  Revision    : 1.0 - initial parametrised fetch stage
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = C_ADDR_W,
    parameter int unsigned       INST_W   = C_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(C_RESET_PC),
    parameter int unsigned       PC_STEP  = C_PC_STEP,
    parameter int unsigned       QDEPTH   = C_QDEPTH
) (
    input  wire logic clk,
    input  wire logic rst_n,
    fetch_if.master   bus
);
    localparam int unsigned CNT_W   = $clog2(QDEPTH) + 1;
    localparam int unsigned USED_W  = CNT_W + 1;
    localparam int unsigned ENTRY_W = INST_W + ADDR_W;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic              r_ice;
    logic              w_ice_next;
    logic              r_inflight;   // response arrives this cycle
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_tag;        // pc of the arriving response
    logic              w_redirect;
    logic              w_misalign_fire;
    logic              w_lock;
    logic              w_pc_load;
    logic              w_push;
    logic              w_pop;
    logic              w_q_full;
    logic              w_q_empty;
    logic [CNT_W-1:0]  w_q_count;
    logic [USED_W-1:0] w_used;
    logic [ENTRY_W-1:0] w_head;

    // Redirects are ignored while booting.
    assign w_redirect = bus.redirect_valid && (r_state != S_BOOT);

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign;

    assign w_misalign_fire = w_redirect && (bus.redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) r_misalign <= 1'b0;
        else        r_misalign <= r_misalign | w_misalign_fire;
    end

    assign w_lock = r_misalign;
`else
    assign w_misalign_fire = 1'b0;
    assign w_lock          = 1'b0;
`endif

    assign bus.misalign = w_lock;
    assign w_pc_load    = w_redirect && !w_misalign_fire;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_BOOT;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT:  w_state_next = S_RUN;
            S_RUN:   if (bus.halt)  w_state_next = S_HALT;
            S_HALT:  if (!bus.halt) w_state_next = S_RUN;
            default: w_state_next = S_BOOT;
        endcase
        if (w_misalign_fire || w_lock) w_state_next = S_HALT;
    end

    // Credit counts queued entries, the response arriving now and the
    // request on the bus now, so every response is guaranteed a slot even
    // if decode never pops.
    assign w_used     = USED_W'(w_q_count) + USED_W'(r_inflight) + USED_W'(r_ice);
    assign w_ice_next = (r_state == S_RUN) && !bus.halt && !bus.redirect_valid
                        && (w_used < USED_W'(QDEPTH));

    // ------------------------------------------------------------------
    // PC / request tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_ice      <= 1'b0;
            r_inflight <= 1'b0;
            r_tag      <= '0;
        end else begin
            r_ice      <= w_ice_next;
            // A redirect squashes the request currently on the bus.
            r_inflight <= r_ice && !w_redirect;
            if (r_ice) r_tag <= r_pc;
            if (w_pc_load)
                r_pc <= bus.redirect_pc;
            else if (r_ice && !w_misalign_fire)
                r_pc <= r_pc + ADDR_W'(PC_STEP);
        end
    end

    assign bus.ice   = r_ice;
    assign bus.iaddr = r_ice ? r_pc : '0;

    // ------------------------------------------------------------------
    // Queue toward decode
    // ------------------------------------------------------------------
    assign w_push = r_inflight && !w_redirect && !w_q_full;
    assign w_pop  = !w_q_empty && bus.id_ready;

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .WIDTH  (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({bus.idata, r_tag}),
        .pop       (w_pop),
        .flush     (w_redirect),
        .pop_data  (w_head),
        .count     (w_q_count),
        .full      (w_q_full),
        .empty     (w_q_empty)
    );

    assign bus.id_valid = !w_q_empty;
    assign bus.id_inst  = w_head[ENTRY_W-1:ADDR_W];
    assign bus.id_pc    = w_head[ADDR_W-1:0];
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. Directed scenarios for
//                reset, sequential fetch, backpressure, redirect, halt and
//                pc wrap, then a randomized run checked against a stream
//                model: issued and delivered addresses must each form the
//                sequential program order, restarting at every redirect.
//                The misalign scenario runs when FETCH_MISALIGN_CHK_EN is set.
//  Revision    : 1.0 - initial parametrised fetch stage
// ============================================================================
module tb_fetch_unit;
    localparam logic [31:0] MASK = 32'hFFFF_0000;
    localparam int          QD   = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

    fetch_unit #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0000_3000),
        .PC_STEP  (4),
        .QDEPTH   (QD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // 1-cycle synchronous memory; junk when not enabled so that a squashed
    // or spurious delivery shows up as a wrong instruction word.
    always @(posedge clk) bus.idata <= bus.ice ? (bus.iaddr ^ MASK) : $urandom();

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        bus.id_ready       = 1'b1;
    endtask

    // Returns just after the last reset edge with rst_n released.
    task automatic do_reset(input logic ready);
        drive_idle();
        bus.id_ready = ready;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.ice, bus.iaddr} !== 33'd0) begin
            failures++;
            $display("FAIL reset_ice got ice=%0b iaddr=%h want ice=0 iaddr=0", bus.ice, bus.iaddr);
        end
        checks++;
        if (bus.id_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_id_valid got=%0b want=0", bus.id_valid);
        end
        checks++;
        if (bus.misalign !== 1'b0) begin
            failures++;
            $display("FAIL reset_misalign got=%0b want=0", bus.misalign);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.ice !== 1'b0) begin
            failures++;
            $display("FAIL boot_ice got=%0b want=0", bus.ice);
        end
        step();
        checks++;
        if ({bus.ice, bus.iaddr} !== {1'b1, 32'h0000_3000}) begin
            failures++;
            $display("FAIL first_issue got ice=%0b iaddr=%h want ice=1 iaddr=00003000", bus.ice, bus.iaddr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] ep;
        do_reset(1'b1);
        repeat (2) step();
        for (int k = 0; k < 6; k++) begin
            ep = 32'h3000 + 32'(4 * k);
            checks++;
            if ({bus.ice, bus.iaddr} !== {1'b1, ep}) begin
                failures++;
                $display("FAIL seq_iaddr k=%0d got ice=%0b iaddr=%h want ice=1 iaddr=%h", k, bus.ice, bus.iaddr, ep);
            end
            if (k >= 2) begin
                ep = 32'h3000 + 32'(4 * (k - 2));
                checks++;
                if ({bus.id_valid, bus.id_pc, bus.id_inst} !== {1'b1, ep, ep ^ MASK}) begin
                    failures++;
                    $display("FAIL seq_deliver k=%0d got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                             k, bus.id_valid, bus.id_pc, bus.id_inst, ep, ep ^ MASK);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int          n = 0;
        int          pops = 0;
        logic [31:0] ei = 32'h3010;
        logic [31:0] ep = 32'h3000;
        do_reset(1'b0);
        for (int c = 0; c < 15; c++) begin
            step();
            if (bus.ice) begin
                checks++;
                if (bus.iaddr !== 32'h3000 + 32'(4 * n)) begin
                    failures++;
                    $display("FAIL bp_iaddr got=%h want=%h", bus.iaddr, 32'h3000 + 32'(4 * n));
                end
                n++;
            end
        end
        checks++;
        if (n != QD) begin
            failures++;
            $display("FAIL bp_issue_count got=%0d want=%0d", n, QD);
        end
        bus.id_ready = 1'b1;
        for (int c = 0; c < 40 && pops < 8; c++) begin
            if (bus.ice) begin
                checks++;
                if (bus.iaddr !== ei) begin
                    failures++;
                    $display("FAIL bp_resume_iaddr got=%h want=%h", bus.iaddr, ei);
                end
                ei += 4;
            end
            if (bus.id_valid) begin
                checks++;
                if ({bus.id_pc, bus.id_inst} !== {ep, ep ^ MASK}) begin
                    failures++;
                    $display("FAIL bp_deliver got pc=%h inst=%h want pc=%h inst=%h", bus.id_pc, bus.id_inst, ep, ep ^ MASK);
                end
                ep += 4;
                pops++;
            end
            step();
        end
        checks++;
        if (pops < 8) begin
            failures++;
            $display("FAIL bp_timeout got pops=%0d want=8", pops);
        end
    endtask

    task automatic test_redirect();
        int   n = 0;
        logic seen_ice = 1'b0;
        logic done = 1'b0;
        do_reset(1'b0);
        for (int c = 0; c < 20 && n < 4; c++) begin
            step();
            if (bus.ice) n++;
        end
        step();
        checks++;
        if (bus.id_valid !== 1'b1 || n != 4) begin
            failures++;
            $display("FAIL redir_setup got id_valid=%0b issued=%0d want id_valid=1 issued=4", bus.id_valid, n);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h4000;
        step();
        bus.redirect_valid = 1'b0;
        checks++;
        if ({bus.id_valid, bus.ice} !== 2'b00) begin
            failures++;
            $display("FAIL redir_flush got id_valid=%0b ice=%0b want 0 0", bus.id_valid, bus.ice);
        end
        bus.id_ready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (bus.ice && !seen_ice) begin
                seen_ice = 1'b1;
                checks++;
                if (bus.iaddr !== 32'h4000) begin
                    failures++;
                    $display("FAIL redir_iaddr got=%h want=00004000", bus.iaddr);
                end
            end
            if (bus.id_valid) begin
                done = 1'b1;
                checks++;
                if ({bus.id_pc, bus.id_inst} !== {32'h4000, 32'h4000 ^ MASK}) begin
                    failures++;
                    $display("FAIL redir_deliver got pc=%h inst=%h want pc=00004000 inst=%h", bus.id_pc, bus.id_inst, 32'h4000 ^ MASK);
                end
            end
            step();
        end
        checks++;
        if (!done || !seen_ice) begin
            failures++;
            $display("FAIL redir_timeout got ice_seen=%0b delivered=%0b want 1 1", seen_ice, done);
        end
    endtask

    task automatic test_halt();
        int          n = 0;
        int          got = 0;
        logic        done = 1'b0;
        logic [31:0] ep = 32'h3000;
        do_reset(1'b0);
        for (int c = 0; c < 20 && n < 2; c++) begin
            step();
            if (bus.ice) n++;
        end
        bus.halt     = 1'b1;
        bus.id_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (bus.ice !== 1'b0) begin
                failures++;
                $display("FAIL halt_ice cycle=%0d got=%0b want=0", c, bus.ice);
            end
            if (bus.id_valid) begin
                checks++;
                if (bus.id_pc !== ep) begin
                    failures++;
                    $display("FAIL halt_drain got pc=%h want=%h", bus.id_pc, ep);
                end
                ep += 4;
                got++;
            end
        end
        checks++;
        if (got != 2) begin
            failures++;
            $display("FAIL halt_drain_count got=%0d want=2", got);
        end
        bus.halt = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            if (bus.ice) begin
                done = 1'b1;
                checks++;
                if (bus.iaddr !== 32'h3008) begin
                    failures++;
                    $display("FAIL halt_resume got iaddr=%h want=00003008", bus.iaddr);
                end
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL halt_timeout got no issue want issue at 00003008");
        end
    endtask

    task automatic test_wrap();
        int          ni = 0;
        int          nd = 0;
        logic [31:0] ew;
        do_reset(1'b1);
        repeat (4) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        for (int c = 0; c < 20 && (ni < 2 || nd < 2); c++) begin
            step();
            ew = (ni == 0) ? 32'hFFFF_FFFC : 32'h0;
            if (bus.ice && ni < 2) begin
                checks++;
                if (bus.iaddr !== ew) begin
                    failures++;
                    $display("FAIL wrap_iaddr got=%h want=%h", bus.iaddr, ew);
                end
                ni++;
            end
            ew = (nd == 0) ? 32'hFFFF_FFFC : 32'h0;
            if (bus.id_valid && nd < 2) begin
                checks++;
                if ({bus.id_pc, bus.id_inst} !== {ew, ew ^ MASK}) begin
                    failures++;
                    $display("FAIL wrap_deliver got pc=%h inst=%h want pc=%h inst=%h", bus.id_pc, bus.id_inst, ew, ew ^ MASK);
                end
                nd++;
            end
        end
        checks++;
        if (ni < 2 || nd < 2) begin
            failures++;
            $display("FAIL wrap_timeout got issued=%0d delivered=%0d want 2 2", ni, nd);
        end
    endtask

    // Stream model: in each epoch (from reset or a redirect) issued and
    // delivered addresses both advance by 4 from the epoch start, the
    // number issued-but-not-delivered never exceeds the queue depth, and a
    // halt or redirect suppresses the next request.
    task automatic test_random();
        logic [31:0] exp_i = 32'h3000;
        logic [31:0] exp_p = 32'h3000;
        logic [31:0] tgt;
        int          outst = 0;
        int          pops = 0;
        logic        halt_prev = 1'b0;
        logic        redir_prev = 1'b0;
        logic        redir;
        do_reset(1'b1);
        repeat (2) step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (redir_prev) begin
                checks++;
                if ({bus.ice, bus.id_valid} !== 2'b00) begin
                    failures++;
                    $display("FAIL rnd_after_redirect cyc=%0d got ice=%0b id_valid=%0b want 0 0", cyc, bus.ice, bus.id_valid);
                end
            end else if (halt_prev) begin
                checks++;
                if (bus.ice !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_halt_ice cyc=%0d got=%0b want=0", cyc, bus.ice);
                end
            end
            if (bus.ice) begin
                checks++;
                if (bus.iaddr !== exp_i) begin
                    failures++;
                    $display("FAIL rnd_iaddr cyc=%0d got=%h want=%h", cyc, bus.iaddr, exp_i);
                end
                exp_i += 4;
                outst++;
            end
            bus.id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) bus.halt = ~bus.halt;
            redir = ($urandom_range(0, 39) == 0);
            tgt   = $urandom() & 32'hFFFF_FFFC;
            bus.redirect_valid = redir;
            bus.redirect_pc    = tgt;
            if (bus.id_valid && bus.id_ready) begin
                checks++;
                if ({bus.id_pc, bus.id_inst} !== {exp_p, exp_p ^ MASK}) begin
                    failures++;
                    $display("FAIL rnd_deliver cyc=%0d got pc=%h inst=%h want pc=%h inst=%h",
                             cyc, bus.id_pc, bus.id_inst, exp_p, exp_p ^ MASK);
                end
                exp_p += 4;
                outst--;
                pops++;
            end
            if (redir) begin
                exp_i = tgt;
                exp_p = tgt;
                outst = 0;
            end
            checks++;
            if (outst < 0 || outst > QD) begin
                failures++;
                $display("FAIL rnd_outstanding cyc=%0d got=%0d want 0..%0d", cyc, outst, QD);
            end
            halt_prev  = bus.halt;
            redir_prev = redir;
            step();
        end
        drive_idle();
        checks++;
        if (pops < 300) begin
            failures++;
            $display("FAIL rnd_progress got pops=%0d want>=300", pops);
        end
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        do_reset(1'b1);
        repeat (4) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h4002;
        step();
        bus.redirect_valid = 1'b0;
        checks++;
        if ({bus.misalign, bus.id_valid} !== 2'b10) begin
            failures++;
            $display("FAIL mis_set got misalign=%0b id_valid=%0b want 1 0", bus.misalign, bus.id_valid);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if ({bus.misalign, bus.ice, bus.id_valid} !== 3'b100) begin
                failures++;
                $display("FAIL mis_hold cycle=%0d got misalign=%0b ice=%0b id_valid=%0b want 1 0 0",
                         c, bus.misalign, bus.ice, bus.id_valid);
            end
        end
        do_reset(1'b1);
        checks++;
        if (bus.misalign !== 1'b0) begin
            failures++;
            $display("FAIL mis_clear got=%0b want=0", bus.misalign);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_random();
`ifdef FETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the basic PC/fetch stage; generates instruction addresses, tracks a fixed 1-cycle synchronous I-memory read, and buffers returned words in a small queue toward decode.
- Adds over the basic stage:
  - configurable reset vector, address width, step and queue depth;
  - branch/jump redirect with flush of queued and in-flight instructions;
  - halt control;
  - valid/ready backpressure from decode.

Parameters:
- ADDR_W, 32, width of pc/iaddr/redirect_pc.
- INST_W, 32, instruction word width.
- RESET_PC, 32'h00003000, pc value after reset (ADDR_W bits).
- PC_STEP, 4, sequential pc increment.
- QDEPTH, 4, instruction queue entries; power of 2, >=2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ice  out  1  I-memory read enable (registered).
- iaddr  out  ADDR_W  read address; equals pc when ice=1, else 0.
- idata  in  INST_W  I-memory read data, valid exactly 1 cycle after ice=1.
- redirect_valid  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  ADDR_W  redirect target.
- halt  in  1  level; suspends issue while 1.
- id_valid  out  1  queue head valid to decode.
- id_inst  out  INST_W  queue head instruction.
- id_pc  out  ADDR_W  address the head instruction was fetched from.
- id_ready  in  1  decode accepts head.
- misalign  out  1  sticky misaligned-redirect flag (only with feature; tied 0 otherwise).

Behaviour:
- Reset: while rst_n=0 at a clk edge:
  - pc<=RESET_PC, ice<=0, queue empty, id_valid=0, in-flight flag=0, misalign<=0, state<=S_BOOT.
- FSM states: S_BOOT, S_RUN, S_HALT.
  - S_BOOT -> S_RUN after one cycle. First ice=1 occurs the second edge after rst_n rises, same as the basic stage.
  - S_RUN -> S_HALT when halt=1.
  - S_HALT -> S_RUN when halt=0.
  - S_HALT -> S_HALT, with the misalign flag held, when the misalign feature fires.
- Issue:
  - ice_next = (state==S_RUN) && !halt && !redirect_valid && (count + inflight + issue_now) < QDEPTH.
  - The credit check includes the request being registered, so a returned word always has a free slot.
  - On each cycle with ice=1, pc<=pc+PC_STEP (mod 2^ADDR_W; wraps silently) and inflight<=1 with tag pc.
- Response: the cycle after ice=1, if not squashed, push {idata, tagged pc} into the queue.
- Pop: when id_valid && id_ready. Simultaneous push and pop keeps count unchanged. Push never occurs when full (guaranteed by credit).
- Redirect (highest priority, any state except S_BOOT):
  - pc<=redirect_pc; queue flushed (count<=0, id_valid<=0 next cycle);
  - the in-flight response returning next cycle is squashed;
  - ice<=0 for that cycle; fetch of redirect_pc issues the following cycle if in S_RUN.
  - A pop in the redirect cycle is still honoured (decode saw it).
- Redirect while halted: pc updated, queue flushed, no issue until halt=0.
- Halt does not flush; queued instructions still drain to decode.
- id_inst/id_pc: driven from the head entry; don't-care when id_valid=0.
- Reset mid-operation: all state discarded in one cycle; returning idata ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - redirect_valid with redirect_pc[1:0]!=0 sets misalign<=1 (sticky until reset);
  - flushes the queue and forces S_HALT permanently, ignoring halt;
  - pc is not updated.
- Undefined: misalign tied 0; low address bits accepted unchecked.

Decomposition:
- Package fetch_pkg:
  - state enum (S_BOOT/S_RUN/S_HALT);
  - default RESET_PC, PC_STEP, INST_W constants;
  - queue entry struct {inst, pc}.
- Sub-module fetch_queue:
  - synchronous FIFO, parameters QDEPTH and entry width;
  - push/pop/flush, count, full/empty;
  - same clk/rst_n, synchronous reset.

Test Plan:
- Reset release, id_ready=1, memory returns idata=addr^32'hFFFF0000:
  - ice=0 first cycle after rst_n rises;
  - iaddr 0x3000, 0x3004, 0x3008 on successive cycles;
  - id_pc/id_inst follow one cycle later with no gaps.
- id_ready=0 from start, QDEPTH=4: exactly 4 requests issued (0x3000-0x300C), then ice=0. Raising id_ready resumes at 0x3010 with no lost or duplicated pc.
- redirect_valid pulse with redirect_pc=0x4000 while the queue holds 3 entries and 1 is in flight:
  - id_valid=0 next cycle;
  - squashed response not delivered;
  - next iaddr=0x4000, and next delivered id_pc=0x4000.
- halt=1 for 5 cycles with the queue half full: ice=0 during halt; queue drains to decode; fetch resumes at the correct sequential pc after halt=0.
- pc near 2^ADDR_W-4 via redirect_pc=0xFFFFFFFC: the following iaddr=0x00000000 (wrap).
- With FETCH_MISALIGN_CHK_EN, redirect_pc=0x4002:
  - misalign=1 next cycle and stays 1;
  - ice stays 0; queue empty;
  - only rst_n=0 clears it.
